seq_ctrl: RTL
=============

Name: seq_ctrl

Overview:
Multi-cycle instruction sequencer that drives the ALU/register-file/RAM datapath (alu_mod).
- Fetches instruction words from an instruction memory through a req/ack handshake.
- Decodes each word into datapath control fields and holds them stable across execution.
- Gates the datapath write enable so only one write-back cycle happens per instruction.
- Owns the program counter and resolves jumps, conditional jumps on zero_flag, stack push/pop pulses and halt.

Parameters:
WIDTH, 8, datapath word width (source1/source2/destination fields)
IWIDTH, 8, op_code width
SOURCES, 4, number of ALU operand sources; choice fields are $clog2(SOURCES) bits
ADDR_WIDTH, 8, destination address width
PC_WIDTH, 6, program counter / instruction address width
INSTR_WIDTH, 40, instruction word width (fixed layout below)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin execution at PC 0; honoured only in IDLE or HALT
busy  out  1  high in FETCH/DECODE/EXEC/WB
halted  out  1  high in HALT
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_WIDTH  fetch address (= PC)
imem_ack  in  1  instruction valid this cycle
imem_data  in  INSTR_WIDTH  instruction word
op_code  out  IWIDTH  ALU operation
source1, source2  out  WIDTH  operand fields
source1_choice, source2_choice  out  $clog2(SOURCES)  operand source selects
destination  out  ADDR_WIDTH  write address
dest_choice  out  2  00 reg file, 01 bit RAM, 10 word RAM, 11 no write
push, pop  out  1  one-cycle stack strobes
instr_addr  out  PC_WIDTH  PC of the instruction currently executing
zero_flag  in  1  flag register Z output

Behaviour:
Instruction layout:
- [39:32] op_code
- [31:30] dest_choice
- [29:28] src1_choice
- [27:26] src2_choice
- [25:24] class: 00 ALU, 01 JMP, 10 JZ, 11 SYS
- [23:16] destination
- [15:8] source1
- [7:0] source2
- SYS sub-op is source2[1:0]: 00 NOP, 01 PUSH, 10 POP, 11 HALT.

States: IDLE, FETCH, DECODE, EXEC, WB, HALT.

Reset:
- Enters IDLE with PC=0.
- All control outputs are 0, except dest_choice=11.
- imem_req=0, push=pop=0, busy=0, halted=0.
- Reset mid-instruction aborts it: no write and no strobe occur in the reset cycle or after it.

IDLE/HALT:
- On start, set PC=0 and go to FETCH.
- start is ignored in every other state.

FETCH:
- imem_req=1 and imem_addr=PC.
- Waits any number of cycles for imem_ack; ack and data are sampled together.
- On ack, latch the instruction register and go to DECODE.
- imem_ack outside FETCH is ignored.

DECODE (1 cycle):
- Drive all fields from the instruction register, with dest_choice forced to 11.
- The fields stay stable through EXEC and WB.
- This cycle lets the synchronous RAM/reg-file reads settle.

EXEC (1 cycle):
- ALU: go to WB.
- JMP: PC = destination[PC_WIDTH-1:0], then FETCH.
- JZ: if zero_flag=1, PC = target; otherwise PC = PC+1. Then FETCH.
- zero_flag is sampled in EXEC; it reflects the previous instruction's write-back.
- SYS NOP: PC+1, then FETCH.
- SYS PUSH: push=1 for this cycle, PC+1, then FETCH.
- SYS POP: pop=1 for this cycle, PC+1, then FETCH.
- SYS HALT: go to HALT with PC unchanged.
- dest_choice stays 11 for every class in EXEC.

WB (1 cycle):
- dest_choice = decoded value; this is the only cycle a write can occur.
- An ALU instruction with dest_choice=11 performs no write but still uses the cycle.
- PC = PC+1, then FETCH.

Timing and widths:
- Latency with zero-wait fetch: ALU = 4 cycles; JMP/JZ/SYS = 3 cycles.
- PC arithmetic is modulo 2^PC_WIDTH, so 2^PC_WIDTH-1 wraps to 0.
- The jump target is truncated to PC_WIDTH bits.
- instr_addr equals the PC of the current instruction from DECODE through WB.
- push and pop are never asserted together or for more than one cycle.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the state enum;
  - class codes and SYS sub-op codes;
  - dest_choice encodings, including DEST_NONE=2'b11;
  - instruction field bit offsets.
- One combinational sub-module, instr_decode, splits the instruction register into fields and class/sub-op flags.
- The FSM, PC and strobes live in seq_ctrl.

Test Plan:
- Reset then start, imem_ack 2 cycles late, ALU instruction with dest_choice=00 and destination=0x03 → dest_choice=00 only in the WB cycle; imem_addr steps 0 then 1.
- JMP to 0x2A at PC 5 → next imem_addr=0x2A; dest_choice stays 11 throughout; 3 cycles from ack to next imem_req.
- JZ with target 0x10: once with zero_flag=1 → next fetch at 0x10; once with zero_flag=0 at PC 7 → next fetch at 8.
- PUSH then POP back to back → push pulses 1 cycle in the first EXEC, pop pulses 1 cycle in the second; never overlapping.
- ALU instruction at PC 63 (PC_WIDTH=6) → next fetch at 0; a HALT instruction then gives halted=1 and busy=0 with PC held; start restarts at 0.
- Assert rst during WB of a word-RAM write → dest_choice=11 in that cycle, FSM in IDLE next cycle, start ignored during FETCH.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the seq_ctrl instruction sequencer.
// Covers the FSM state encoding, the instruction classes and the instruction word layout.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    ClsAlu = 2'b00,
    ClsJmp = 2'b01,
    ClsJz  = 2'b10,
    ClsSys = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    SysNop  = 2'b00,
    SysPush = 2'b01,
    SysPop  = 2'b10,
    SysHalt = 2'b11
  } sys_op_e;

  localparam logic [1:0] DEST_REG  = 2'b00;
  localparam logic [1:0] DEST_BIT  = 2'b01;
  localparam logic [1:0] DEST_WORD = 2'b10;
  localparam logic [1:0] DEST_NONE = 2'b11;

  // Bit offsets of the fields in the instruction word.
  localparam int unsigned OP_LSB          = 32;
  localparam int unsigned DEST_CHOICE_LSB = 30;
  localparam int unsigned SRC1_CHOICE_LSB = 28;
  localparam int unsigned SRC2_CHOICE_LSB = 26;
  localparam int unsigned CLASS_LSB       = 24;
  localparam int unsigned DEST_LSB        = 16;
  localparam int unsigned SRC1_LSB        = 8;
  localparam int unsigned SRC2_LSB        = 0;

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational instruction splitter: slices the instruction register into datapath
// fields plus the class and SYS sub-op codes used by the sequencer FSM.
module instr_decode
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned IWIDTH      = 8,
  parameter int unsigned SOURCES     = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 40
) (
  input  logic [INSTR_WIDTH-1:0]     instr,
  output logic [IWIDTH-1:0]          op_code,
  output logic [1:0]                 dest_choice,
  output logic [$clog2(SOURCES)-1:0] source1_choice,
  output logic [$clog2(SOURCES)-1:0] source2_choice,
  output logic [ADDR_WIDTH-1:0]      destination,
  output logic [WIDTH-1:0]           source1,
  output logic [WIDTH-1:0]           source2,
  output instr_class_e               instr_cls,
  output sys_op_e                    sys_op
);

  localparam int unsigned ChoiceWidth = $clog2(SOURCES);

  assign op_code        = instr[OP_LSB +: IWIDTH];
  assign dest_choice    = instr[DEST_CHOICE_LSB +: 2];
  assign source1_choice = instr[SRC1_CHOICE_LSB +: ChoiceWidth];
  assign source2_choice = instr[SRC2_CHOICE_LSB +: ChoiceWidth];
  assign instr_cls      = instr_class_e'(instr[CLASS_LSB +: 2]);
  assign destination    = instr[DEST_LSB +: ADDR_WIDTH];
  assign source1        = instr[SRC1_LSB +: WIDTH];
  assign source2        = instr[SRC2_LSB +: WIDTH];
  // The SYS sub-op lives in the low bits of the source2 field.
  assign sys_op         = sys_op_e'(instr[SRC2_LSB +: 2]);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetches over a req/ack port, decodes, and steps the
// alu_mod datapath through DECODE/EXEC/WB while owning the PC, stack strobes and halt.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned IWIDTH      = 8,
  parameter int unsigned SOURCES     = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned PC_WIDTH    = 6,
  parameter int unsigned INSTR_WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       halted,
  output logic                       imem_req,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  output logic [IWIDTH-1:0]          op_code,
  output logic [WIDTH-1:0]           source1,
  output logic [WIDTH-1:0]           source2,
  output logic [$clog2(SOURCES)-1:0] source1_choice,
  output logic [$clog2(SOURCES)-1:0] source2_choice,
  output logic [ADDR_WIDTH-1:0]      destination,
  output logic [1:0]                 dest_choice,
  output logic                       push,
  output logic                       pop,
  output logic [PC_WIDTH-1:0]        instr_addr,
  input  logic                       zero_flag
);

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    instr_addr_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic                   req_q;
  logic                   busy_q;
  logic                   halted_q;
  logic                   push_q;
  logic                   pop_q;
  logic [1:0]             dest_q;

  logic [1:0]             dec_dest_choice;
  instr_class_e           instr_cls;
  sys_op_e                sys_op;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [PC_WIDTH-1:0]    jump_target;

  instr_decode #(
    .WIDTH      (WIDTH),
    .IWIDTH     (IWIDTH),
    .SOURCES    (SOURCES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_decode (
    .instr         (ir_q),
    .op_code       (op_code),
    .dest_choice   (dec_dest_choice),
    .source1_choice(source1_choice),
    .source2_choice(source2_choice),
    .destination   (destination),
    .source1       (source1),
    .source2       (source2),
    .instr_cls     (instr_cls),
    .sys_op        (sys_op)
  );

  assign pc_inc      = pc_q + 1'b1;
  assign jump_target = destination[PC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      instr_addr_q <= '0;
      ir_q         <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      dest_q       <= DEST_NONE;
    end else begin
      // Strobes and the write-enable encoding only live for the single cycle they are set up for.
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      dest_q <= DEST_NONE;
      unique case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            pc_q     <= '0;
            state_q  <= StFetch;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        StFetch: begin
          if (imem_ack) begin
            ir_q         <= imem_data;
            instr_addr_q <= pc_q;
            req_q        <= 1'b0;
            state_q      <= StDecode;
          end
        end
        StDecode: begin
          state_q <= StExec;
          if (instr_cls == ClsSys) begin
            push_q <= (sys_op == SysPush);
            pop_q  <= (sys_op == SysPop);
          end
        end
        StExec: begin
          unique case (instr_cls)
            ClsAlu: begin
              state_q <= StWb;
              dest_q  <= dec_dest_choice;
            end
            ClsJmp: begin
              pc_q    <= jump_target;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
            ClsJz: begin
              pc_q    <= zero_flag ? jump_target : pc_inc;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
            ClsSys: begin
              if (sys_op == SysHalt) begin
                state_q  <= StHalt;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end else begin
                pc_q    <= pc_inc;
                state_q <= StFetch;
                req_q   <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
        StWb: begin
          pc_q    <= pc_inc;
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign halted     = halted_q;
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign instr_addr = instr_addr_q;

  // Reset must suppress a write or strobe already registered for the current cycle.
  assign dest_choice = rst ? DEST_NONE : dest_q;
  assign push        = push_q & ~rst;
  assign pop         = pop_q & ~rst;

  push_pop_exclusive: assert property (@(posedge clk) disable iff (rst) !(push && pop));
  push_single_cycle:  assert property (@(posedge clk) disable iff (rst) push |=> !push);
  pop_single_cycle:   assert property (@(posedge clk) disable iff (rst) pop |=> !pop);

endmodule
